// File: rtl/lfsr_pkg.sv
// Shared types and the Galois step function for the LFSR bank.
// Holds the warm-up FSM state type and a width-generic lfsr_next.
package lfsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WARM = 1'b1
    } state_t;

    localparam int MAX_WIDTH = 64;

    // Galois step on the low 'width' bits; upper bits of the result are 0.
    function automatic logic [MAX_WIDTH-1:0] lfsr_next(
        input logic [MAX_WIDTH-1:0] s,
        input logic [MAX_WIDTH-1:0] taps,
        input int                   width,
        input logic                 invert
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] msb_sel;
        logic                 fb;
        if (width >= MAX_WIDTH) begin
            mask = '1;
        end else begin
            mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
        end
        msb_sel = s >> (width - 1);
        fb      = msb_sel[0] ^ invert;
        return ((s << 1) & mask) ^ (fb ? (taps & mask) : '0);
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational next state and fixed-point detection for one channel.
// Ports: s (current state), nxt (stepped state), fixed (nxt == s).
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'b00011101,
    parameter int               INVERT = 0
) (
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] nxt,
    output logic             fixed
);

    assign nxt = WIDTH'(lfsr_next(MAX_WIDTH'(s), MAX_WIDTH'(TAPS),
                                  WIDTH, (INVERT != 0)));
    assign fixed = (nxt == s);

endmodule

// File: rtl/lfsr_bank.sv
// Bank of NCHAN Galois LFSRs with seed load, warm-up and lock-up recovery.
// Ports: clk, reset_n (sync, active low), enable, load_valid/ready/chan/seed,
// lfsr_out, valid, lockup, wrap. Macro LFSR_BANK_PERIOD_EN adds per-channel
// seed registers so wrap can flag period completion; otherwise wrap is 0.
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'b00011101,
    parameter int               INVERT       = 0,
    parameter int               NCHAN        = 4,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 1,
    parameter int               WARMUP       = 2
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic [NCHAN-1:0]                          enable,
    input  logic                                      load_valid,
    output logic                                      load_ready,
    input  logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0] load_chan,
    input  logic [WIDTH-1:0]                          load_seed,
    output logic [NCHAN*WIDTH-1:0]                    lfsr_out,
    output logic [NCHAN-1:0]                          valid,
    output logic [NCHAN-1:0]                          lockup,
    output logic [NCHAN-1:0]                          wrap
);

    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    state_t           state, state_n;
    logic [7:0]       cnt, cnt_n;
    logic [CW-1:0]    wchan;
    logic [WIDTH-1:0] lfsr     [NCHAN];
    logic [WIDTH-1:0] nxt      [NCHAN];
    logic [WIDTH-1:0] step_val [NCHAN];
    logic [NCHAN-1:0] fixed;
    logic [NCHAN-1:0] ld, wm, st;
    logic             fire, chan_ok, warm_done;

    function automatic logic [WIDTH-1:0] rst_seed(input int c);
        int n;
        n = c % WIDTH;
        return (DEFAULT_SEED << n) | (DEFAULT_SEED >> (WIDTH - n));
    endfunction

    for (genvar g = 0; g < NCHAN; g++) begin : g_ch
        lfsr_step #(
            .WIDTH  (WIDTH),
            .TAPS   (TAPS),
            .INVERT (INVERT)
        ) u_step (
            .s     (lfsr[g]),
            .nxt   (nxt[g]),
            .fixed (fixed[g])
        );
        assign lfsr_out[g*WIDTH +: WIDTH] = lfsr[g];
    end

    assign load_ready = reset_n && (state == IDLE);
    assign fire       = load_valid && load_ready;
    assign chan_ok    = 32'(load_chan) < NCHAN;
    assign warm_done  = (state == WARM) && (cnt == 8'd1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (fire && chan_ok && (WARMUP > 0)) begin
                    state_n = WARM;
                    cnt_n   = 8'(WARMUP);
                end
            end
            WARM: begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A load always beats a step; the warming channel steps regardless of enable.
    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            ld[c]       = fire && chan_ok && (32'(load_chan) == c);
            wm[c]       = (state == WARM) && (32'(wchan) == c);
            st[c]       = !ld[c] && (wm[c] || enable[c]);
            step_val[c] = fixed[c] ? DEFAULT_SEED : nxt[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            wchan  <= '0;
            valid  <= '1;
            lockup <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                lfsr[c] <= rst_seed(c);
            end
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (fire) begin
                wchan <= load_chan;
            end
            for (int c = 0; c < NCHAN; c++) begin
                if (ld[c]) begin
                    lfsr[c]   <= load_seed;
                    lockup[c] <= 1'b0;
                    if (WARMUP > 0) begin
                        valid[c] <= 1'b0;
                    end
                end else if (st[c]) begin
                    lfsr[c] <= step_val[c];
                    if (fixed[c]) begin
                        lockup[c] <= 1'b1;
                    end
                    if (wm[c] && warm_done) begin
                        valid[c] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef LFSR_BANK_PERIOD_EN
    logic [WIDTH-1:0] seed [NCHAN];
    logic [NCHAN-1:0] wrap_q;

    // Only ordinary steps count toward a period; warm-up steps are excluded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wrap_q <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                seed[c] <= rst_seed(c);
            end
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                wrap_q[c] <= st[c] && !wm[c] && (step_val[c] == seed[c]);
                if (ld[c]) begin
                    seed[c] <= load_seed;
                end
            end
        end
    end

    assign wrap = wrap_q;
`else
    assign wrap = '0;
`endif

endmodule

// File: tb/tb_lfsr_bank.sv
// Self-checking bench for lfsr_bank (WIDTH=5, TAPS=00101, NCHAN=4, WARMUP=2).
// Random and directed stimulus compared against a behavioural model.
module tb_lfsr_bank;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  enable = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [1:0]  load_chan = '0;
    logic [4:0]  load_seed = '0;
    logic [19:0] lfsr_out;
    logic [3:0]  valid;
    logic [3:0]  lockup;
    logic [3:0]  wrap;

    always #5 clk = ~clk;

    lfsr_bank #(
        .WIDTH        (5),
        .TAPS         (5'b00101),
        .INVERT       (0),
        .NCHAN        (4),
        .DEFAULT_SEED (5'd1),
        .WARMUP       (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_chan  (load_chan),
        .load_seed  (load_seed),
        .lfsr_out   (lfsr_out),
        .valid      (valid),
        .lockup     (lockup),
        .wrap       (wrap)
    );

    int checks = 0;
    int passes = 0;

    int m_s    [4];
    int m_seed [4];
    bit m_valid[4];
    bit m_lock [4];
    bit m_wrap [4];
    int m_warm = 0;
    int m_wchan = 0;

    logic ready_obs;
    logic ready_exp;

    // Galois step with polynomial x^5 + x^2 + 1 in plain arithmetic.
    function automatic int mstep(input int s);
        int v;
        v = s * 2;
        if (v >= 32) v = (v - 32) ^ 5;
        return v;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_s[c]     = 1 << (c % 5);
            m_seed[c]  = m_s[c];
            m_valid[c] = 1'b1;
            m_lock[c]  = 1'b0;
            m_wrap[c]  = 1'b0;
        end
        m_warm  = 0;
        m_wchan = 0;
    endfunction

    function automatic void model_apply(input bit r, input logic [3:0] e,
                                        input bit lv, input int lc,
                                        input int ls);
        bit fire, ld, wm;
        int n;
        if (!r) begin
            model_reset();
            return;
        end
        fire = lv && (m_warm == 0);
        for (int c = 0; c < 4; c++) begin
            m_wrap[c] = 1'b0;
            ld = fire && (lc == c);
            wm = (m_warm > 0) && (m_wchan == c);
            if (ld) begin
                m_s[c]     = ls;
                m_seed[c]  = ls;
                m_lock[c]  = 1'b0;
                m_valid[c] = 1'b0;
            end else if (wm || e[c]) begin
                n = mstep(m_s[c]);
                if (n == m_s[c]) begin
                    n = 1;
                    m_lock[c] = 1'b1;
                end
`ifdef LFSR_BANK_PERIOD_EN
                m_wrap[c] = !wm && (n == m_seed[c]);
`endif
                m_s[c] = n;
                if (wm && m_warm == 1) m_valid[c] = 1'b1;
            end
        end
        if (m_warm > 0) m_warm--;
        if (fire) begin
            m_warm  = 2;
            m_wchan = lc;
        end
    endfunction

    function automatic logic [31:0] exp_all();
        logic [19:0] o;
        logic [3:0]  v, l, w;
        for (int c = 0; c < 4; c++) begin
            o[c*5 +: 5] = 5'(m_s[c]);
            v[c] = m_valid[c];
            l[c] = m_lock[c];
            w[c] = m_wrap[c];
        end
        return {o, v, l, w};
    endfunction

    task automatic cycle(input bit r, input logic [3:0] e, input bit lv,
                         input logic [1:0] lc, input logic [4:0] ls);
        @(negedge clk);
        reset_n    = r;
        enable     = e;
        load_valid = lv;
        load_chan  = lc;
        load_seed  = ls;
        #1;
        ready_obs = load_ready;
        ready_exp = r && (m_warm == 0);
        model_apply(r, e, lv, int'(lc), int'(ls));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [19:0] rst_out;
        rst_out = {5'b01000, 5'b00100, 5'b00010, 5'b00001};
        cycle(0, 4'hF, 1, 2'd1, 5'h1F);
        cycle(0, 4'hF, 1, 2'd1, 5'h1F);
        checks++;
        if (lfsr_out !== rst_out)
            $display("FAIL reset_out: got %b expected %b", lfsr_out, rst_out);
        else passes++;
        checks++;
        if ({valid, lockup, wrap} !== 12'hF00)
            $display("FAIL reset_flags: got %h expected f00", {valid, lockup, wrap});
        else passes++;
        checks++;
        if (ready_obs !== 1'b0)
            $display("FAIL reset_ready: got %b expected 0", ready_obs);
        else passes++;
        cycle(1, 4'h0, 0, 2'd0, 5'h0);
        checks++;
        if (ready_obs !== 1'b1)
            $display("FAIL ready_after_reset: got %b expected 1", ready_obs);
        else passes++;
        checks++;
        if (lfsr_out !== rst_out)
            $display("FAIL hold_after_reset: got %b expected %b", lfsr_out, rst_out);
        else passes++;
    endtask

    task automatic test_step();
        logic [4:0] seq [5];
        seq = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00101};
        cycle(0, 4'h0, 0, 2'd0, 5'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 4'b0001, 0, 2'd0, 5'h0);
            checks++;
            if (lfsr_out[4:0] !== seq[i])
                $display("FAIL step_ch0[%0d]: got %b expected %b", i, lfsr_out[4:0], seq[i]);
            else passes++;
            checks++;
            if ({lfsr_out, valid, lockup, wrap} !== exp_all())
                $display("FAIL step_model[%0d]: got %h expected %h", i,
                         {lfsr_out, valid, lockup, wrap}, exp_all());
            else passes++;
        end
    endtask

    task automatic test_load_warm();
        logic [4:0] ch1 [3];
        logic       rdy [4];
        logic       vld [3];
        ch1 = '{5'b00001, 5'b00010, 5'b00100};
        vld = '{1'b0, 1'b0, 1'b1};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1};
        cycle(0, 4'h0, 0, 2'd0, 5'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 4'h0, (i == 0), 2'd1, 5'b00001);
            checks++;
            if (ready_obs !== rdy[i])
                $display("FAIL load_ready[%0d]: got %b expected %b", i, ready_obs, rdy[i]);
            else passes++;
            if (i < 3) begin
                checks++;
                if ({lfsr_out[9:5], valid[1]} !== {ch1[i], vld[i]})
                    $display("FAIL load_ch1[%0d]: got %b/%b expected %b/%b", i,
                             lfsr_out[9:5], valid[1], ch1[i], vld[i]);
                else passes++;
            end
            checks++;
            if ({lfsr_out, valid, lockup, wrap} !== exp_all())
                $display("FAIL load_model[%0d]: got %h expected %h", i,
                         {lfsr_out, valid, lockup, wrap}, exp_all());
            else passes++;
        end
    endtask

    task automatic test_lockup();
        cycle(0, 4'h0, 0, 2'd0, 5'h0);
        cycle(1, 4'b0100, 1, 2'd2, 5'h00);
        checks++;
        if ({lfsr_out[14:10], lockup[2]} !== {5'h00, 1'b0})
            $display("FAIL lock_load: got %b/%b expected 00000/0", lfsr_out[14:10], lockup[2]);
        else passes++;
        cycle(1, 4'b0100, 0, 2'd0, 5'h0);
        checks++;
        if ({lfsr_out[14:10], lockup[2]} !== {5'b00001, 1'b1})
            $display("FAIL lock_recover: got %b/%b expected 00001/1", lfsr_out[14:10], lockup[2]);
        else passes++;
        cycle(1, 4'b0000, 0, 2'd0, 5'h0);
        cycle(1, 4'b0000, 1, 2'd2, 5'h0B);
        checks++;
        if ({lfsr_out[14:10], lockup[2]} !== {5'h0B, 1'b0})
            $display("FAIL lock_clear: got %b/%b expected 01011/0", lfsr_out[14:10], lockup[2]);
        else passes++;
        checks++;
        if ({lfsr_out, valid, lockup, wrap} !== exp_all())
            $display("FAIL lock_model: got %h expected %h",
                     {lfsr_out, valid, lockup, wrap}, exp_all());
        else passes++;
    endtask

    task automatic test_back_to_back();
        cycle(0, 4'h0, 0, 2'd0, 5'h0);
        cycle(1, 4'b1000, 1, 2'd3, 5'h0A);
        checks++;
        if (lfsr_out[19:15] !== 5'h0A)
            $display("FAIL load_wins: got %b expected 01010", lfsr_out[19:15]);
        else passes++;
        cycle(1, 4'b1000, 0, 2'd0, 5'h0);
        checks++;
        if ({lfsr_out, valid, lockup, wrap} !== exp_all())
            $display("FAIL mid_warm: got %h expected %h",
                     {lfsr_out, valid, lockup, wrap}, exp_all());
        else passes++;
        cycle(0, 4'b1000, 0, 2'd0, 5'h0);
        checks++;
        if ({lfsr_out, valid, lockup, wrap} !== {5'b01000, 5'b00100, 5'b00010, 5'b00001, 12'hF00})
            $display("FAIL warm_reset: got %h expected %h", {lfsr_out, valid, lockup, wrap},
                     {5'b01000, 5'b00100, 5'b00010, 5'b00001, 12'hF00});
        else passes++;
        cycle(1, 4'h0, 0, 2'd0, 5'h0);
        checks++;
        if (ready_obs !== 1'b1)
            $display("FAIL warm_abort_ready: got %b expected 1", ready_obs);
        else passes++;
    endtask

    task automatic test_wrap();
        int bad;
        bad = 0;
        cycle(0, 4'h0, 0, 2'd0, 5'h0);
        for (int i = 1; i <= 32; i++) begin
            cycle(1, 4'b0001, 0, 2'd0, 5'h0);
            checks++;
            if ({lfsr_out, valid, lockup, wrap} !== exp_all())
                $display("FAIL wrap_model[%0d]: got %h expected %h", i,
                         {lfsr_out, valid, lockup, wrap}, exp_all());
            else passes++;
            if (i == 31) begin
                checks++;
`ifdef LFSR_BANK_PERIOD_EN
                if ({lfsr_out[4:0], wrap} !== {5'b00001, 4'b0001})
`else
                if ({lfsr_out[4:0], wrap} !== {5'b00001, 4'b0000})
`endif
                    $display("FAIL wrap_31: got %b/%b", lfsr_out[4:0], wrap);
                else passes++;
            end
        end
    endtask

    task automatic test_random();
        bit         r, lv;
        logic [3:0] e;
        logic [1:0] lc;
        logic [4:0] ls;
        cycle(0, 4'h0, 0, 2'd0, 5'h0);
        for (int i = 0; i < 500; i++) begin
            r  = ($urandom_range(0, 99) != 0);
            e  = 4'($urandom);
            lv = ($urandom_range(0, 3) == 0);
            lc = 2'($urandom);
            ls = ($urandom_range(0, 4) == 0) ? 5'h0 : 5'($urandom);
            cycle(r, e, lv, lc, ls);
            checks++;
            if (ready_obs !== ready_exp)
                $display("FAIL rand_ready[%0d]: got %b expected %b", i, ready_obs, ready_exp);
            else passes++;
            checks++;
            if ({lfsr_out, valid, lockup, wrap} !== exp_all())
                $display("FAIL rand_state[%0d]: got %h expected %h", i,
                         {lfsr_out, valid, lockup, wrap}, exp_all());
            else passes++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_step();
        test_load_warm();
        test_lockup();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
